// File: rtl/spec_vram_pkg.sv
// Shared types and constants for the Specialist video-RAM arbiter.
package spec_vram_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_VPIX = 3'd1,
    S_VCOL = 3'd2,
    S_VEND = 3'd3,
    S_CPU  = 3'd4,
    S_CACK = 3'd5
  } vstate_t;

  localparam logic [15:0] PIX_BASE_DEF  = 16'h9000;
  localparam logic [15:0] COL_BASE_DEF  = 16'hD000;
  localparam logic [7:0]  DEF_COLOR_DEF = 8'h07;
  localparam int          VID_BUDGET    = 7;

  // Plane address: 16-bit modulo sum, carry out of bit 15 dropped.
  function automatic logic [15:0] vid_addr(input logic [15:0] base, input logic [13:0] off);
    return base + {2'b00, off};
  endfunction

endpackage

// File: rtl/spec_vram_arb.sv
// Video-RAM arbiter: video fetches preempt CPU slots on one 8-bit SRAM.
// Define VRAM_COLOR_EN to read the colour plane; otherwise DEF_COLOR is used.
module spec_vram_arb
  import spec_vram_pkg::*;
#(
  parameter logic [15:0] PIX_BASE  = PIX_BASE_DEF,
  parameter logic [15:0] COL_BASE  = COL_BASE_DEF,
  parameter logic [7:0]  DEF_COLOR = DEF_COLOR_DEF
) (
  input  logic        clkVid,
  input  logic        rst_n,
  input  logic        rdvid,
  input  logic [13:0] vram,
  output logic [15:0] vdata,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_ack,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_din,
  output logic        mem_we,
  input  logic [7:0]  mem_dout
);

  vstate_t state, state_nxt;
  logic    vid_pend;
  logic    vid_go;
  logic    cpu_rd;

`ifdef VRAM_COLOR_EN
  logic [13:0] vram_q;
  logic [7:0]  pix_byte;
`else
  logic unused_col;
  assign unused_col = ^COL_BASE;
`endif

  assign vid_go = rdvid | vid_pend;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (vid_go)       state_nxt = S_VPIX;
        else if (cpu_req) state_nxt = S_CPU;
      end
`ifdef VRAM_COLOR_EN
      S_VPIX:  state_nxt = S_VCOL;
`else
      S_VPIX:  state_nxt = S_VEND;
`endif
      S_VCOL:  state_nxt = S_VEND;
      S_VEND:  state_nxt = S_IDLE;
      S_CPU:   state_nxt = S_CACK;
      S_CACK:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clkVid) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clkVid) begin
    if (!rst_n) begin
      vid_pend  <= 1'b0;
      vdata     <= 16'h0000;
      cpu_rdata <= 8'h00;
      cpu_ack   <= 1'b0;
      cpu_rd    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_din   <= 8'h00;
      mem_we    <= 1'b0;
    end else begin
      cpu_ack <= 1'b0;
      // A strobe seen mid-sequence is remembered until the next S_VPIX entry.
      if (state == S_IDLE && vid_go) vid_pend <= 1'b0;
      else if (rdvid)                vid_pend <= 1'b1;

      case (state)
        S_IDLE: begin
          if (vid_go) begin
            mem_addr <= vid_addr(PIX_BASE, vram);
          end else if (cpu_req) begin
            mem_addr <= cpu_addr;
            mem_din  <= cpu_wdata;
            mem_we   <= cpu_we;
            cpu_rd   <= ~cpu_we;
          end
        end
`ifdef VRAM_COLOR_EN
        S_VPIX: mem_addr <= vid_addr(COL_BASE, vram_q);
        S_VCOL: pix_byte <= mem_dout;
        S_VEND: vdata    <= {mem_dout, pix_byte};
`else
        S_VEND: vdata    <= {DEF_COLOR, mem_dout};
`endif
        S_CPU:  mem_we   <= 1'b0;
        S_CACK: begin
          if (cpu_rd) cpu_rdata <= mem_dout;
          cpu_ack <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef VRAM_COLOR_EN
  // Offset held for the colour read in case the generator moves on.
  always_ff @(posedge clkVid) begin
    if (state == S_IDLE && vid_go) vram_q <= vram;
  end
`endif

endmodule

// File: doc/spec_vram_arb.md
# spec_vram_arb

Shared video-RAM arbiter sitting directly upstream of the Specialist video generator. Services the generator's one-cycle `rdvid` fetch strobe by reading the pixel-plane byte and the colour-plane byte at the generator's 14-bit `vram` offset, and presents them as the 16-bit `vdata` word before the generator latches it. CPU accesses to the same 8-bit synchronous SRAM run in the remaining slots through a req/ack handshake. Video always has priority.

## Interface
Parameters:
- PIX_BASE, 16'h9000, pixel-plane base address.
- COL_BASE, 16'hD000, colour-plane base address.
- DEF_COLOR, 8'h07, colour byte used when the colour plane is compiled out.

Ports:
- clkVid  in  1  pixel clock; the only clock.
- rst_n  in  1  reset, synchronous, active-low.
- rdvid  in  1  video fetch strobe; one-cycle pulse per 8 clocks.
- vram  in  14  video offset {column[5:0], line[7:0]}.
- vdata  out  16  {colour byte, pixel byte}; registered.
- cpu_req  in  1  CPU access request; held high until `cpu_ack`.
- cpu_we  in  1  1 = write, 0 = read; stable while `cpu_req` is high.
- cpu_addr  in  16  CPU address.
- cpu_wdata  in  8  CPU write data.
- cpu_rdata  out  8  CPU read data; valid in the `cpu_ack` cycle and held afterwards.
- cpu_ack  out  1  one-cycle completion pulse.
- mem_addr  out  16  SRAM address; registered.
- mem_din  out  8  SRAM write data; registered.
- mem_we  out  1  SRAM write enable; registered, active-high.
- mem_dout  in  8  SRAM read data; valid one cycle after the address cycle.

## Operation
- Video pending flag `vid_pend`:
  - Set on any edge that samples `rdvid=1`.
  - Cleared on entry to S_VPIX.
- FSM states: S_IDLE, S_VPIX, S_VCOL, S_VEND, S_CPU, S_CACK.
- Transitions out of S_IDLE:
  - S_VPIX if `rdvid` or `vid_pend`.
  - Otherwise S_CPU if `cpu_req`.
  - Otherwise stay in S_IDLE.
- Video sequence:
  - Entering S_VPIX: `mem_addr <= PIX_BASE + vram`.
  - S_VPIX → S_VCOL: `mem_addr <= COL_BASE + vram`.
  - S_VCOL → S_VEND: capture `mem_dout` as the pixel byte.
  - S_VEND → S_IDLE: capture `mem_dout` as the colour byte and update `vdata` with both bytes at the same edge.
- CPU sequence:
  - Entering S_CPU: `mem_addr <= cpu_addr`, `mem_din <= cpu_wdata`, `mem_we <= cpu_we`.
  - S_CPU → S_CACK: `mem_we <= 0`.
  - S_CACK → S_IDLE: `cpu_rdata <= mem_dout` (reads only; holds its value on writes) and `cpu_ack <= 1` for one cycle.
- A CPU access that has started always completes. Video waits at most 2 cycles.
- `rdvid` arriving during S_VPIX…S_VEND is latched in `vid_pend` and serviced next. Under normal generator timing this does not happen.
- Simultaneous `rdvid` and `cpu_req` in S_IDLE: video wins. The CPU request stays pending.
- Address arithmetic is 16-bit modulo: `{2'b00, vram}` is added to the base, and the carry is dropped.
- `mem_we` is asserted only in S_CPU, and never during a video state.

## Timing
- Reset values: `vdata` = 16'h0000, `cpu_rdata` = 8'h00, `cpu_ack` = 0, `mem_addr` = 16'h0000, `mem_din` = 8'h00, `mem_we` = 0, state = S_IDLE, `vid_pend` = 0.
- Latency from the edge sampling `rdvid` (S_IDLE) to the `vdata` update: 4 edges.
- Worst case, when the CPU access started the cycle before: 6 edges, which is inside the generator's 7-edge budget.
- CPU latency from the edge sampling `cpu_req` in S_IDLE to the `cpu_ack` pulse: 3 edges, plus up to 4 edges of video blocking.
- After `cpu_ack` the CPU drops `cpu_req` on the next edge. A request still high after S_CACK is treated as a new access.
- Reset mid-operation:
  - The sequence is aborted and `mem_we` drops at the reset edge.
  - No `cpu_ack` is issued.
  - `vdata` returns to 0.

## Configuration
- `VRAM_COLOR_EN` defined:
  - Full two-read video sequence as described above.
  - `vdata[15:8]` = colour-plane byte.
- `VRAM_COLOR_EN` undefined:
  - S_VCOL is removed; S_VPIX → S_VEND.
  - S_VEND captures the pixel byte.
  - `vdata` = {DEF_COLOR, pixel byte}.
  - Video latency is 3 edges.
  - COL_BASE is unused.

## Structure
- Package `spec_vram_pkg`:
  - State enum (6 states).
  - Default PIX_BASE, COL_BASE and DEF_COLOR constants.
  - `VID_BUDGET` = 7.
- Single flat module; no sub-module is warranted.

## Test plan
- Reset, then `rdvid` with `vram` = 14'h0123 and memory holding [9123]=8'hA5, [D123]=8'h03 → `vdata` = 16'h03A5 exactly 4 edges later. `mem_we` stays 0 throughout.
- CPU write of 8'h5A to 16'h9000, then CPU read of 16'h9000:
  - Write: `mem_we` is high for exactly one cycle and `cpu_ack` pulses 3 edges after the request is sampled.
  - Read: `cpu_rdata` = 8'h5A in the `cpu_ack` cycle.
- `rdvid` and `cpu_req` asserted on the same edge:
  - The video sequence runs first and `vdata` updates at edge 4.
  - The CPU access then starts and `cpu_ack` pulses at edge 7.
- `cpu_req` sampled one edge before `rdvid`:
  - The CPU access completes first.
  - `vdata` updates 6 edges after `rdvid`.
- `vram` = 14'h3FFF with COL_BASE = 16'hD000 → colour read at 16'h0FFF (wrap), with no X on `mem_addr`.
- `rst_n` asserted in S_CPU during a write:
  - `mem_we` = 0 at the next edge.
  - No `cpu_ack` is issued.
  - Everything returns to reset values.
  - Repeat this with `VRAM_COLOR_EN` undefined and check `vdata[15:8]` = DEF_COLOR.
